// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scan-code receiver.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_t;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;
  localparam int         CODE_W         = 10;

endpackage

// File: rtl/ps2_code_fifo.sv
// First-word fall-through FIFO for folded scan codes; a push while full is
// accepted only when a pop frees the slot in the same cycle.
module ps2_code_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_scan_rx.sv
// PS/2 keyboard receiver: synchronise, glitch-filter, frame, fold E0/F0 prefixes
// and queue codes. Define PS2_PARITY_CHECK_EN to enforce odd parity.
// Handshake: code_data is transferred on any cycle where code_valid && code_ready;
// code_valid never drops and code_data never changes until that transfer happens.
module ps2_scan_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 4,
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ps2_clk,
  input  logic              ps2_data,
  output logic [CODE_W-1:0] code_data,
  output logic              code_valid,
  input  logic              code_ready,
  output logic              frame_err,
  output logic              overflow,
  output ps2_state_t        dbg_state
);

  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);

  logic clk_s1, clk_s2, dat_s1, dat_s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
    end
  end

  // The filtered level flips on the FILTER_LEN-th consecutive differing sample.
  logic [FCW-1:0] filt_cnt;
  logic           filt_clk;
  logic           filt_flip;
  logic           bit_event;

  assign filt_flip = (clk_s2 != filt_clk) && (filt_cnt == FCW'(FILTER_LEN - 1));
  assign bit_event = filt_flip && filt_clk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_clk <= 1'b1;
      filt_cnt <= '0;
    end else if (clk_s2 == filt_clk) begin
      filt_cnt <= '0;
    end else if (filt_flip) begin
      filt_clk <= clk_s2;
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + 1'b1;
    end
  end

  ps2_state_t state, state_n;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic [7:0] shift, shift_n;
  logic       done_n, err_n;
  logic       done_q, err_q;
  logic       par_ok;
  logic [TW-1:0] to_cnt;
  logic       timeout;

  assign timeout = (state != ST_IDLE) && !bit_event && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

`ifdef PS2_PARITY_CHECK_EN
  logic par, par_n;
  assign par_ok = ^{shift, par};
`else
  assign par_ok = 1'b1;
`endif

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shift_n   = shift;
    done_n    = 1'b0;
    err_n     = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
    par_n     = par;
`endif
    if (timeout) begin
      state_n = ST_IDLE;
      err_n   = 1'b1;
    end else if (bit_event) begin
      case (state)
        ST_IDLE: begin
          if (!dat_s2) begin
            state_n   = ST_DATA;
            bit_cnt_n = '0;
          end
        end
        ST_DATA: begin
          shift_n   = {dat_s2, shift[7:1]};
          bit_cnt_n = bit_cnt + 1'b1;
          if (bit_cnt == 3'd7) state_n = ST_PARITY;
        end
        ST_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
          par_n = dat_s2;
`endif
          state_n = ST_STOP;
        end
        ST_STOP: begin
          state_n = ST_IDLE;
          if (dat_s2 && par_ok) done_n = 1'b1;
          else                  err_n  = 1'b1;
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      shift   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      to_cnt  <= '0;
`ifdef PS2_PARITY_CHECK_EN
      par     <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      shift   <= shift_n;
      done_q  <= done_n;
      err_q   <= err_n;
      to_cnt  <= (bit_event || state == ST_IDLE) ? '0 : to_cnt + 1'b1;
`ifdef PS2_PARITY_CHECK_EN
      par     <= par_n;
`endif
    end
  end

  // shift still holds the completed byte while done_q is high (it only moves in DATA).
  logic flag_ext, flag_brk;
  logic push, pop, fifo_full, fifo_empty, ovf_q;
  logic [CODE_W-1:0] head;

  assign push = done_q && (shift != PS2_PREFIX_EXT) && (shift != PS2_PREFIX_BRK);
  assign pop  = code_valid && code_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_ext <= 1'b0;
      flag_brk <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      ovf_q <= push && fifo_full && !pop;
      if (err_q) begin
        flag_ext <= 1'b0;
        flag_brk <= 1'b0;
      end else if (done_q) begin
        if (shift == PS2_PREFIX_EXT)      flag_ext <= 1'b1;
        else if (shift == PS2_PREFIX_BRK) flag_brk <= 1'b1;
        else begin
          flag_ext <= 1'b0;
          flag_brk <= 1'b0;
        end
      end
    end
  end

  ps2_code_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (CODE_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({flag_ext, flag_brk, shift}),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (head)
  );

  assign code_valid = !fifo_empty;
  assign code_data  = fifo_empty ? '0 : head;
  assign frame_err  = err_q;
  assign overflow   = ovf_q;
  assign dbg_state  = state;

endmodule

// File: tb/tb_ps2_scan_rx.sv
// Directed bench for ps2_scan_rx: table of frames plus overflow, timeout,
// glitch and reset sequences.
module tb_ps2_scan_rx;
  import ps2_pkg::*;

  localparam int TO_CYC = 200;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              ps2_clk = 1'b1;
  logic              ps2_data = 1'b1;
  logic [CODE_W-1:0] code_data;
  logic              code_valid;
  logic              code_ready = 1'b1;
  logic              frame_err;
  logic              overflow;
  ps2_state_t        dbg_state;

  ps2_scan_rx #(
    .FILTER_LEN     (4),
    .FIFO_DEPTH     (8),
    .TIMEOUT_CYCLES (TO_CYC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .code_data  (code_data),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .frame_err  (frame_err),
    .overflow   (overflow),
    .dbg_state  (dbg_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int err_cnt  = 0;
  int ovf_cnt  = 0;
  logic [CODE_W-1:0] got_q[$];
  logic [CODE_W-1:0] exp_q[$];

  // Scoreboard side: observe accepted codes and error pulses mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (code_valid && code_ready) got_q.push_back(code_data);
      if (frame_err) err_cnt++;
      if (overflow)  ovf_cnt++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic ps2_bit(input logic b, input logic glitch);
    ps2_data = b;
    if (glitch) begin
      cycles(4);
      ps2_clk = 1'b0;
      cycles(1);
      ps2_clk = 1'b1;
      cycles(5);
    end else begin
      cycles(10);
    end
    ps2_clk = 1'b0;
    cycles(20);
    ps2_clk = 1'b1;
    cycles(10);
  endtask

  // Sends the first nbits of a frame (11 = full frame).
  task automatic send_frame(input logic [7:0] b, input logic flip, input logic glitch,
                            input int nbits);
    logic [10:0] fr;
    fr = {1'b1, (~^b) ^ flip, b, 1'b0};
    for (int i = 0; i < nbits; i++) ps2_bit(fr[i], glitch);
    ps2_data = 1'b1;
  endtask

  typedef struct {
    logic [7:0]        b;
    logic              flip;
    logic              glitch;
    logic              exp_push;
    logic [CODE_W-1:0] exp_code;
    int                exp_err;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int e0, o0;
    vecs[0] = '{8'h1C, 1'b0, 1'b0, 1'b1, 10'h01C, 0};
    vecs[1] = '{8'hE0, 1'b0, 1'b0, 1'b0, 10'h000, 0};
    vecs[2] = '{8'hF0, 1'b0, 1'b0, 1'b0, 10'h000, 0};
    vecs[3] = '{8'h75, 1'b0, 1'b0, 1'b1, 10'h375, 0};
`ifdef PS2_PARITY_CHECK_EN
    vecs[4] = '{8'h1C, 1'b1, 1'b0, 1'b0, 10'h000, 1};
`else
    vecs[4] = '{8'h1C, 1'b1, 1'b0, 1'b1, 10'h01C, 0};
`endif
    vecs[5] = '{8'h1C, 1'b0, 1'b1, 1'b1, 10'h01C, 0};
    vecs[6] = '{8'hE0, 1'b0, 1'b0, 1'b0, 10'h000, 0};
    vecs[7] = '{8'h74, 1'b0, 1'b0, 1'b1, 10'h274, 0};
    vecs[8] = '{8'hF0, 1'b0, 1'b0, 1'b0, 10'h000, 0};
    vecs[9] = '{8'h29, 1'b0, 1'b0, 1'b1, 10'h129, 0};

    // Reset state
    cycles(3);
    chk("rst_valid", 32'(code_valid), 32'd0);
    chk("rst_data", 32'(code_data), 32'd0);
    chk("rst_ferr", 32'(frame_err), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst = 1'b0;
    cycles(5);

    // Table-driven frames
    for (int i = 0; i < 10; i++) begin
      e0 = err_cnt;
      o0 = ovf_cnt;
      got_q.delete();
      exp_q.delete();
      if (vecs[i].exp_push) exp_q.push_back(vecs[i].exp_code);
      send_frame(vecs[i].b, vecs[i].flip, vecs[i].glitch, 11);
      cycles(5);
      chk($sformatf("v%0d_err", i), 32'(err_cnt - e0), 32'(vecs[i].exp_err));
      chk($sformatf("v%0d_ovf", i), 32'(ovf_cnt - o0), 32'd0);
      chk($sformatf("v%0d_ncodes", i), 32'(got_q.size()), 32'(exp_q.size()));
      while (got_q.size() > 0 && exp_q.size() > 0)
        chk($sformatf("v%0d_code", i), 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
    end

    // Overflow: stall the consumer and send FIFO_DEPTH+1 make codes
    code_ready = 1'b0;
    got_q.delete();
    exp_q.delete();
    o0 = ovf_cnt;
    for (int k = 1; k <= 9; k++) begin
      send_frame(8'(k), 1'b0, 1'b0, 11);
      if (k <= 8) exp_q.push_back(CODE_W'(k));
    end
    cycles(5);
    chk("ovf_pulses", 32'(ovf_cnt - o0), 32'd1);
    chk("ovf_valid_stall", 32'(code_valid), 32'd1);
    chk("ovf_head_stall", 32'(code_data), 32'h001);
    code_ready = 1'b1;
    cycles(15);
    chk("drain_count", 32'(got_q.size()), 32'd8);
    while (got_q.size() > 0 && exp_q.size() > 0)
      chk("drain_code", 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
    chk("drain_empty", 32'(code_valid), 32'd0);

    // Timeout after start + 4 data bits
    got_q.delete();
    e0 = err_cnt;
    send_frame(8'h5A, 1'b0, 1'b0, 5);
    chk("to_busy", 32'(dbg_state != ST_IDLE), 32'd1);
    cycles(TO_CYC + 20);
    chk("to_err", 32'(err_cnt - e0), 32'd1);
    chk("to_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("to_nocode", 32'(got_q.size()), 32'd0);
    send_frame(8'h29, 1'b0, 1'b0, 11);
    cycles(5);
    chk("to_after_n", 32'(got_q.size()), 32'd1);
    if (got_q.size() > 0) chk("to_after_code", 32'(got_q.pop_front()), 32'h029);

    // Reset mid-frame with a queued code and a pending E0 prefix
    code_ready = 1'b0;
    send_frame(8'h1C, 1'b0, 1'b0, 11);
    send_frame(8'hE0, 1'b0, 1'b0, 11);
    cycles(5);
    chk("pre_rst_valid", 32'(code_valid), 32'd1);
    send_frame(8'h33, 1'b0, 1'b0, 4);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", 32'(code_valid), 32'd0);
    chk("mid_rst_data", 32'(code_data), 32'd0);
    chk("mid_rst_ferr", 32'(frame_err), 32'd0);
    chk("mid_rst_ovf", 32'(overflow), 32'd0);
    chk("mid_rst_state", 32'(dbg_state), 32'(ST_IDLE));
    cycles(3);
    rst = 1'b0;
    code_ready = 1'b1;
    got_q.delete();
    cycles(5);
    send_frame(8'h1C, 1'b0, 1'b0, 11);
    cycles(5);
    chk("post_rst_n", 32'(got_q.size()), 32'd1);
    if (got_q.size() > 0) chk("post_rst_code", 32'(got_q.pop_front()), 32'h01C);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ps2_scan_rx.md
# ps2_scan_rx

Parametrised PS/2 keyboard receiver with a glitch-filtered clock input, odd-parity and framing checks, a bit-level timeout, E0/F0 prefix folding and a scan-code FIFO with valid/ready output. It sits between the board PS/2 pins and the game-input decoder. It replaces the single-register, pulse-only receiver, so back-to-back key events are no longer lost when the consumer is busy.

## Interface
- FILTER_LEN, 4: consecutive identical synchronised ps2_clk samples required to change the filtered level (2..15).
- FIFO_DEPTH, 8: scan-code FIFO entries; power of two, 2..64.
- TIMEOUT_CYCLES, 50000: clk cycles without a filtered falling edge before a partial frame is aborted (≥ 16).
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- ps2_clk  in  1  raw PS/2 clock pin; asynchronous to clk.
- ps2_data  in  1  raw PS/2 data pin; asynchronous to clk.
- code_data  out  10  {expand, break, byte}, the FIFO head; reset 0.
- code_valid  out  1  FIFO not empty; reset 0.
- code_ready  in  1  consumer accepts the head when code_valid && code_ready.
- frame_err  out  1  one-cycle pulse on a start, parity, stop or timeout error; reset 0.
- overflow  out  1  one-cycle pulse when a completed code is dropped because the FIFO is full; reset 0.

## Operation
- Both pins pass through 2-flop synchronisers, reset to 1.
- The filtered clock (reset 1) takes the synchronised level only after FILTER_LEN equal consecutive samples. A filtered 1→0 transition is a bit event, and it samples the synchronised ps2_data in the same cycle.
- Frame FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: a bit event with data=0 goes to DATA with bit count 0. A bit event with data=1 is ignored and gives no error.
  - DATA: shift in LSB first. After the 8th bit, go to PARITY.
  - PARITY: latch the parity bit, go to STOP.
  - STOP: data=1 and parity OK completes the byte. data=0 pulses frame_err. Both cases return to IDLE.
- Timeout: a counter clears on every bit event and counts while the state is not IDLE. Reaching TIMEOUT_CYCLES forces IDLE, pulses frame_err and discards the partial byte.
- Prefix folding, applied to completed bytes:
  - 8'hE0 sets the expand flag.
  - 8'hF0 sets the break flag.
  - Any other byte pushes {expand, break, byte} into the FIFO and clears both flags.
  - Every frame_err clears both flags.
- FIFO: first-word fall-through.
  - Push while full drops the code and pulses overflow; the prefix flags are still cleared.
  - Push and pop in the same cycle while full: the pop frees the slot and the push is accepted, with no overflow.
  - Push and pop in the same cycle while empty is not possible, because valid is 0.
- Reset mid-frame returns to IDLE, empties the FIFO, clears both flags and restores all output reset values.

## Timing
- Pin edge to bit event: 2 synchroniser cycles + FILTER_LEN cycles.
- Stop-bit event to FIFO write: 1 cycle. FIFO write to code_valid=1: 1 cycle, for 2 cycles total from the stop event.
- frame_err and overflow assert in the cycle after the detecting event and last exactly 1 cycle.
- code_data is stable while code_valid=1 && code_ready=0. After a pop, the next entry, if any, appears in the following cycle.
- Throughput is one code per PS/2 frame; the FIFO absorbs up to FIFO_DEPTH stalled codes.

## Configuration
- PS2_PARITY_CHECK_EN defined:
  - Odd parity is required: the XOR of the 8 data bits and the parity bit must be 1.
  - A mismatch at STOP pulses frame_err, discards the byte and clears the prefix flags.
- PS2_PARITY_CHECK_EN undefined: the parity bit is sampled and ignored, and only start, stop and timeout errors are reported.

## Structure
- Package ps2_pkg holds:
  - the FSM state enum;
  - the PS2_PREFIX_EXT = 8'hE0 and PS2_PREFIX_BRK = 8'hF0 constants;
  - CODE_W = 10.
- Sub-module ps2_code_fifo is the parametrised FWFT FIFO with push, pop, full, empty and head.
- Synchroniser, filter, FSM and prefix logic stay in ps2_scan_rx.

## Test plan
- Send make code 8'h1C with correct parity, code_ready=1 → one code_valid cycle with code_data=10'h01C; frame_err and overflow stay 0.
- Send E0, F0, 75 (up-arrow release) → a single code 10'h375; the prefixes produce no FIFO entries.
- Hold code_ready=0 and send FIFO_DEPTH+1 make codes 8'h01.. → FIFO_DEPTH entries kept in order, one overflow pulse. Then raise code_ready → the entries drain in order.
- Send 8'h1C with a flipped parity bit → with PS2_PARITY_CHECK_EN: frame_err pulse, no code. Without it: code 10'h01C.
- Stop clocking after 4 data bits for TIMEOUT_CYCLES → frame_err pulse and FSM in IDLE. A following valid 8'h29 frame → code 10'h029.
- Inject 1-cycle ps2_clk glitches shorter than FILTER_LEN during a frame of 8'h1C → no extra bit events and code 10'h01C. Assert rst mid-frame → all outputs 0 and code_valid=0 next cycle.
